div_ctrl: RTL and testbench
===========================

DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; clk is sampled on its rising edge and rst is sampled only on that edge.
REQ-002 clk  in  1  rising-edge system clock.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 start  in  1  EX stage holds DIV/DIVU; opa/opb/signed_div valid; held high by the stalled pipeline.
REQ-005 signed_div  in  1  1 = DIV (two's complement), 0 = DIVU.
REQ-006 opa  in  32  dividend (rs).
REQ-007 opb  in  32  divisor (rt).
REQ-008 cancel  in  1  pipeline flush (exception or ERET); aborts any division in progress.
REQ-009 stall_o  out  1  freeze IF/ID/EX while a division is pending; combinational.
REQ-010 ready_o  out  1  registered one-cycle pulse: result_o valid, HI/LO write enable.
REQ-011 result_o  out  64  registered {HI = remainder, LO = quotient}.

Function
REQ-012 The FSM SHALL have four states: IDLE, RUN, ZERO and DONE.
REQ-013 In IDLE, start=1 and cancel=0 SHALL latch opa, opb and signed_div, then select the next state: ZERO if opb==0, otherwise RUN with iteration counter=0.
REQ-014 Operand changes after the latch SHALL be ignored until the FSM returns to IDLE.
REQ-015 RUN SHALL perform one restoring shift-subtract step per cycle on 32-bit magnitudes (33-bit partial remainder) for exactly 32 cycles, then go to DONE.
REQ-016 Signed mode, before iterating: magnitudes = two's-complement absolute values; quotient sign = sign(opa) XOR sign(opb); remainder sign = sign(opa).
REQ-017 Signed mode, final fix-up: apply both signs in the DONE transition.
REQ-018 0x80000000 / 0xFFFFFFFF signed SHALL yield quotient 0x80000000, remainder 0 (wrap, no trap).
REQ-019 ZERO SHALL last one cycle, then go to DONE with result_o = {opa, 32'hFFFF_FFFF}, for both signed and unsigned.
REQ-020 In DONE, ready_o=1 and result_o are updated on the entry edge; ready_o is high for exactly that one cycle; the next state is IDLE.
REQ-021 start SHALL be ignored in DONE, so the same instruction is never relaunched.
REQ-022 stall_o = ~cancel & ((IDLE & start) | RUN | ZERO); stall_o SHALL be 0 in DONE so the pipeline advances with the result.
REQ-023 Latency from the IDLE cycle T where start is sampled: ready_o at T+33 for a normal division, T+2 for divide-by-zero.
REQ-024 stall_o SHALL be high for 33 cycles (T..T+32) for a normal division and 2 cycles for divide-by-zero.
REQ-025 cancel=1 in RUN or ZERO SHALL force IDLE at the next edge with no ready_o pulse, and stall_o SHALL drop in the same cycle.
REQ-026 cancel=1 in IDLE SHALL block the launch; cancel in DONE SHALL have no effect, since the result is already committed.
REQ-027 result_o SHALL hold its last value until the next DONE.
REQ-028 ready_o SHALL be 0 in every state other than DONE.

Reset
REQ-029 rst=1 SHALL, at the next edge, set the state to IDLE, counter=0, ready_o=0 and result_o=64'h0; stall_o then evaluates to start & ~cancel.
REQ-030 rst SHALL take priority over start and cancel and SHALL abort a RUN mid-operation without producing a ready_o pulse.

Verification
REQ-031 DIVU, opa=100, opb=7, start at T -> stall_o high T..T+32; ready_o at T+33; result_o={32'd2, 32'd14}.
REQ-032 DIV, opa=0xFFFFFFF9 (-7), opb=2 -> at T+33 result_o={32'hFFFFFFFF, 32'hFFFFFFFD}.
REQ-033 DIV, opa=0x80000000, opb=0xFFFFFFFF -> result_o={32'h0, 32'h80000000}, no other side effect.
REQ-034 DIVU, opa=5, opb=0 -> stall_o high T..T+1; ready_o at T+2; result_o={32'd5, 32'hFFFFFFFF}.
REQ-035 Start 100/7, then cancel=1 at T+10 -> stall_o=0 in T+10, FSM in IDLE at T+11, no ready_o; a fresh start of 9/3 at T+12 gives {0, 3} at T+45.
REQ-036 Start 100/7, then rst=1 at T+5 -> from T+6: IDLE, ready_o=0, result_o=0; ready_o never pulses for the aborted division.

Source files
------------

// File: rtl/div_ctrl.sv
// Iterative 32-bit DIV/DIVU unit that stalls the pipeline until a {HI, LO} result is ready.
// Latency: ready_o pulses 33 cycles after launch, or 2 cycles after launch when the divisor is zero.
// Backpressure: stall_o holds the pipeline for the whole operation; cancel aborts it, and start is ignored in DONE.
//
// Ports:
//   clk, rst    rising-edge clock, synchronous active-high reset
//   start       EX stage holds a divide; operands valid (held high while stalled)
//   signed_div  1 = DIV (two's complement), 0 = DIVU
//   opa, opb    dividend / divisor, latched at launch
//   cancel      pipeline flush, aborts any division in progress
//   stall_o     combinational freeze request for IF/ID/EX
//   ready_o     registered one-cycle pulse, result_o valid
//   result_o    registered {HI = remainder, LO = quotient}

module div_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_div,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    input  logic        cancel,
    output logic        stall_o,
    output logic        ready_o,
    output logic [63:0] result_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ZERO = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state;
    logic [4:0]  cnt;      // iteration index, 0..31
    logic [31:0] rem;      // partial remainder between steps
    logic [31:0] quo;      // dividend bits shifting out / quotient bits shifting in
    logic [31:0] dvsr;     // divisor magnitude
    logic        q_neg;    // negate quotient at the end
    logic        r_neg;    // negate remainder at the end

    // Operand magnitudes; unsigned operands pass straight through.
    logic [31:0] mag_a;
    logic [31:0] mag_b;

    always_comb begin
        mag_a = opa;
        mag_b = opb;
        if (signed_div && opa[31]) begin
            mag_a = ~opa + 32'd1;
        end
        if (signed_div && opb[31]) begin
            mag_b = ~opb + 32'd1;
        end
    end

    // One restoring shift-subtract step. The shifted partial remainder is
    // 33 bits wide. Because it is always below 2*dvsr, bit 32 of the 33-bit
    // difference is set exactly when the subtraction would go negative, so
    // it doubles as the "restore" flag.
    logic [32:0] shifted;
    logic [32:0] diff;
    logic        take;
    logic [31:0] step_rem;
    logic [31:0] step_quo;

    always_comb begin
        shifted  = {rem, quo[31]};
        diff     = shifted - {1'b0, dvsr};
        take     = ~diff[32];
        step_rem = take ? diff[31:0] : shifted[31:0];
        step_quo = {quo[30:0], take};
    end

    // Sign fix-up applied on the final step, on its way into result_o.
    // The 32-bit wrap makes 0x80000000 / -1 come out as 0x80000000.
    logic [31:0] fix_q;
    logic [31:0] fix_r;

    always_comb begin
        fix_q = q_neg ? (~step_quo + 32'd1) : step_quo;
        fix_r = r_neg ? (~step_rem + 32'd1) : step_rem;
    end

    // The freeze request is combinational, so a flush releases the pipeline
    // in the same cycle. It stays low in DONE so the result moves on.
    always_comb begin
        stall_o = ~cancel & (((state == IDLE) & start) | (state == RUN) | (state == ZERO));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 5'd0;
            ready_o  <= 1'b0;
            result_o <= 64'h0;
            rem      <= 32'd0;
            quo      <= 32'd0;
            dvsr     <= 32'd0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
        end else begin
            // ready_o is a pulse: only the transition into DONE raises it.
            ready_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !cancel) begin
                        q_neg <= signed_div & (opa[31] ^ opb[31]);
                        r_neg <= signed_div & opa[31];
                        dvsr  <= mag_b;
                        rem   <= 32'd0;
                        cnt   <= 5'd0;
                        if (opb == 32'd0) begin
                            // Keep the raw dividend: it becomes HI untouched.
                            quo   <= opa;
                            state <= ZERO;
                        end else begin
                            quo   <= mag_a;
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (cancel) begin
                        cnt   <= 5'd0;
                        state <= IDLE;
                    end else begin
                        rem <= step_rem;
                        quo <= step_quo;
                        cnt <= cnt + 5'd1;
                        if (cnt == 5'd31) begin
                            state    <= DONE;
                            ready_o  <= 1'b1;
                            result_o <= {fix_r, fix_q};
                        end
                    end
                end
                ZERO: begin
                    if (cancel) begin
                        state <= IDLE;
                    end else begin
                        state    <= DONE;
                        ready_o  <= 1'b1;
                        result_o <= {quo, 32'hFFFF_FFFF};
                    end
                end
                DONE: begin
                    // Result is committed; start and cancel are both ignored here.
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: directed cases plus randomized divisions,
// checked cycle by cycle against an arithmetic reference model.
module tb_div_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        signed_div;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        cancel;
    logic        stall_o;
    logic        ready_o;
    logic [63:0] result_o;

    int n_cmp;
    int n_bad;
    logic [63:0] last_res;   // value result_o is expected to be holding

    div_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .opa        (opa),
        .opb        (opb),
        .cancel     (cancel),
        .stall_o    (stall_o),
        .ready_o    (ready_o),
        .result_o   (result_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: exact 64-bit arithmetic on the true operand values,
    // truncating division, remainder takes the dividend's sign.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] q;
        logic signed [63:0] r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        sa = sgn ? {{32{a[31]}}, a} : {32'd0, a};
        sb = sgn ? {{32{b[31]}}, b} : {32'd0, b};
        q  = sa / sb;
        r  = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Runs one division starting in the next cycle (k = 0 is the launch
    // cycle). cancel_at / rst_at < 0 disable those events; cancel_done
    // raises cancel in the DONE cycle. start is held like a stalled pipeline.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                           input int cancel_at, input int rst_at, input logic cancel_done);
        logic [63:0] exp_res;
        logic [63:0] held;
        int          done;
        exp_res = ref_div(a, b, sgn);
        done    = (b == 32'd0) ? 2 : 33;
        held    = last_res;
        for (int k = 0; k <= done + 1; k++) begin
            @(negedge clk);
            rst    = (k == rst_at);
            cancel = (k == cancel_at) || (cancel_done && k == done);
            start  = (k <= done) && !(cancel_at >= 0 && k > cancel_at) && !(rst_at >= 0 && k > rst_at);
            if (k == 0) begin
                opa = a; opb = b; signed_div = sgn;
            end else begin
                // Operands wander after launch; the latched copy must be used.
                opa = $urandom; opb = $urandom; signed_div = 1'($urandom);
            end
            #1;
            if (rst_at >= 0 && k == rst_at + 1) begin
                chk("rst_stall", {63'd0, stall_o}, 64'd0);
                chk("rst_ready", {63'd0, ready_o}, 64'd0);
                chk("rst_result", result_o, 64'd0);
                last_res = 64'd0;
                return;
            end
            if (cancel_at >= 0 && k == cancel_at + 1) begin
                chk("cancel_stall", {63'd0, stall_o}, 64'd0);
                chk("cancel_ready", {63'd0, ready_o}, 64'd0);
                chk("cancel_hold", result_o, held);
                return;
            end
            chk("stall", {63'd0, stall_o}, {63'd0, (k < done) && (cancel_at < 0 || k < cancel_at)});
            chk("ready", {63'd0, ready_o}, {63'd0, k == done});
            chk("result", result_o, (k >= done) ? exp_res : held);
            if (k == done) last_res = exp_res;
        end
    endtask

    initial begin
        int ca;
        int ra;
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        n_cmp = 0; n_bad = 0; last_res = 64'd0;
        rst = 1'b1; start = 1'b0; cancel = 1'b0; signed_div = 1'b0; opa = 32'd0; opb = 32'd0;

        // Reset state, and stall_o = start & ~cancel while idle.
        repeat (2) @(negedge clk);
        chk("reset_ready", {63'd0, ready_o}, 64'd0);
        chk("reset_result", result_o, 64'd0);
        chk("reset_stall0", {63'd0, stall_o}, 64'd0);
        start = 1'b1; #1;
        chk("reset_stall1", {63'd0, stall_o}, 64'd1);
        cancel = 1'b1; #1;
        chk("reset_stall_cancel", {63'd0, stall_o}, 64'd0);
        @(negedge clk);
        rst = 1'b0; start = 1'b0; cancel = 1'b0;

        // Directed cases.
        run_div(32'd100, 32'd7, 1'b0, -1, -1, 1'b0);
        chk("divu_100_7", result_o, {32'd2, 32'd14});
        run_div(32'hFFFF_FFF9, 32'd2, 1'b1, -1, -1, 1'b0);
        chk("div_m7_2", result_o, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, -1, -1, 1'b0);
        chk("div_overflow", result_o, {32'h0, 32'h8000_0000});
        run_div(32'd5, 32'd0, 1'b0, -1, -1, 1'b0);
        chk("divu_by_zero", result_o, {32'd5, 32'hFFFF_FFFF});
        run_div(32'hFFFF_FFF0, 32'd0, 1'b1, -1, -1, 1'b0);
        chk("div_by_zero", result_o, {32'hFFFF_FFF0, 32'hFFFF_FFFF});
        run_div(32'hFFFF_FFFF, 32'd1, 1'b0, -1, -1, 1'b0);
        run_div(32'd7, 32'hFFFF_FFF9, 1'b1, -1, -1, 1'b0);

        // Flush mid-run, then a fresh launch two cycles later.
        run_div(32'd100, 32'd7, 1'b0, 10, -1, 1'b0);
        run_div(32'd9, 32'd3, 1'b0, -1, -1, 1'b0);
        chk("after_cancel_9_3", result_o, {32'd0, 32'd3});

        // Reset mid-run, flush in IDLE / ZERO, flush in DONE.
        run_div(32'd100, 32'd7, 1'b0, -1, 5, 1'b0);
        run_div(32'd10, 32'd0, 1'b0, 0, -1, 1'b0);
        run_div(32'd7, 32'd0, 1'b0, 1, -1, 1'b0);
        run_div(32'd123456, 32'd789, 1'b1, -1, -1, 1'b1);
        chk("cancel_in_done", result_o, {32'd372, 32'd156});

        // Randomized divisions with occasional flushes and resets.
        for (int i = 0; i < 60; i++) begin
            a = $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'hFFFF_FFFF;
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            s  = 1'($urandom);
            ca = -1;
            ra = -1;
            if ($urandom_range(0, 5) == 0) begin
                ca = $urandom_range(0, (b == 32'd0) ? 1 : 32);
            end else if ($urandom_range(0, 7) == 0) begin
                ra = $urandom_range(1, (b == 32'd0) ? 1 : 32);
            end
            run_div(a, b, s, ca, ra, 1'($urandom_range(0, 7) == 0));
        end

        // Quiet tail: no stray pulse or stall once everything is idle.
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            start = 1'b0; cancel = 1'b0;
            #1;
            chk("tail_ready", {63'd0, ready_o}, 64'd0);
            chk("tail_stall", {63'd0, stall_o}, 64'd0);
        end
        chk("tail_hold", result_o, last_res);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
